// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write bus.
// The loader side uses the slave modport (it sinks the stream and drives the
// memory write port); the host/bench side uses the master modport.
interface imem_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Packs a little-endian byte stream into 32-bit words, writes them to ascending
// word addresses and holds the core in reset until a load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (CHECK state) and an ERR state on mismatch; without it err_o is 0.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [ADDR_W:0] len_words_i,
  imem_loader_if.slave    bus,
  output logic            core_rst_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

  localparam logic [ADDR_W:0]   MaxLen  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LenOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IdxOne  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        byteCnt_q, byteCnt_d;
  logic [31:0]       word_q, word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic            startable;
  logic            accept;
  logic            lastWord;
  logic [ADDR_W:0] lenClamped;

  // Ready and every other output are decoded from state only, so nothing on
  // the stream inputs can reach an output combinationally.
  always_comb begin
    bus.s_ready  = 1'b0;
    bus.im_we    = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    core_rst_o   = 1'b0;
    unique case (state_q)
      LOAD:  begin bus.s_ready = 1'b1; busy_o = 1'b1; end
      WRITE: begin bus.im_we   = 1'b1; busy_o = 1'b1; end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin bus.s_ready = 1'b1; busy_o = 1'b1; end
      ERR:   err_o = 1'b1;
`endif
      DONE:  begin done_o = 1'b1; core_rst_o = 1'b1; end
      default: ;
    endcase
  end

  assign bus.im_addr  = {{(30-ADDR_W){1'b0}}, idx_q, 2'b00};
  assign bus.im_wdata = word_q;

  assign accept     = bus.s_valid & bus.s_ready;
  assign lastWord   = (({1'b0, idx_q} + LenOne) == len_q);
  assign lenClamped = (len_words_i > MaxLen) ? MaxLen : len_words_i;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign startable = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
`else
  assign startable = (state_q == IDLE) || (state_q == DONE);
`endif

  // Next-state logic: start handling in the resting states, byte packing in
  // LOAD, index advance in WRITE and checksum comparison in CHECK.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    byteCnt_d = byteCnt_q;
    word_d    = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    if (startable && start_i) begin
      len_d     = lenClamped;
      idx_d     = '0;
      byteCnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_d     = '0;
      state_d   = (lenClamped == '0) ? CHECK : LOAD;
`else
      state_d   = (lenClamped == '0) ? DONE : LOAD;
`endif
    end else begin
      unique case (state_q)
        LOAD: begin
          if (accept) begin
            word_d[{byteCnt_q, 3'b000} +: 8] = bus.s_data;
            byteCnt_d = byteCnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d = xor_q ^ bus.s_data;
`endif
            if (byteCnt_q == 2'd3) state_d = WRITE;
          end
        end
        WRITE: begin
          idx_d = idx_q + IdxOne;
          if (lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = LOAD;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) state_d = (bus.s_data == xor_q) ? DONE : ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  // State register; reset discards any partial word and drops a pending write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      byteCnt_q <= '0;
      word_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      byteCnt_q <= byteCnt_d;
      word_q    <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected memory writes are
// queued as stimulus is prepared and popped by a monitor on every im_we.
// Builds with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
  localparam int ADDR_W = 10;

  typedef logic [7:0] byteQ_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [ADDR_W:0] lenWords = '0;
  logic            coreRst, busy, done, err;

  wr_t expQ[$];
  int  writeCycles[$];
  int  cycle = 0;
  int  checks = 0;
  int  passes = 0;
  wr_t monExp;

  imem_loader_if bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .len_words_i(lenWords),
    .bus        (bus),
    .core_rst_o (coreRst),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  // Free-running clock and cycle counter used for write spacing.
  always #5 clk = ~clk;

  // Cycle counter advances on each rising edge.
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every write strobe must match the head of the scoreboard and
  // must never coincide with s_ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.im_we === 1'b1) begin
      writeCycles.push_back(cycle);
      checks++;
      if (bus.s_ready !== 1'b0)
        $display("[TB] FAIL ready_in_write got %b want 0", bus.s_ready);
      else
        passes++;
      checks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_write got addr %h data %h want none", bus.im_addr, bus.im_wdata);
      end else begin
        monExp = expQ.pop_front();
        if (bus.im_addr !== monExp.addr || bus.im_wdata !== monExp.data)
          $display("[TB] FAIL write got addr %h data %h want addr %h data %h",
                   bus.im_addr, bus.im_wdata, monExp.addr, monExp.data);
        else
          passes++;
      end
    end
  end

  // Safety net against a hung handshake.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives bytes one by one; toggle inserts an idle cycle after each accept.
  task automatic applyStimulus(input byteQ_t bytes, input bit toggle);
    for (int i = 0; i < bytes.size(); i++) begin
      bit accepted = 1'b0;
      int waitCycles = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = bytes[i];
      while (!accepted && waitCycles < 20) begin
        @(negedge clk);
        if (bus.s_ready === 1'b1) begin
          @(posedge clk);
          #1;
          accepted = 1'b1;
        end else begin
          waitCycles++;
        end
      end
      if (!accepted) begin
        checks++;
        $display("[TB] FAIL byte_accept got no ready want ready for byte %0d", i);
        bus.s_valid = 1'b0;
        return;
      end
      if (toggle) begin
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic pulseStart(input logic [ADDR_W:0] len);
    @(posedge clk);
    #1;
    start    = 1'b1;
    lenWords = len;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lenWords = '0;
  endtask

  task automatic waitIdle(input int limit);
    for (int n = 0; n < limit && busy === 1'b1; n++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL wait_idle got busy %b want 0", busy);
    else passes++;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    checks++;
    if ({bus.s_ready, bus.im_we, bus.im_addr, bus.im_wdata, coreRst, busy, done, err} !== '0)
      $display("[TB] FAIL reset_outputs got %b%b %h %h %b%b%b%b want all zero",
               bus.s_ready, bus.im_we, bus.im_addr, bus.im_wdata, coreRst, busy, done, err);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (coreRst !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL idle_after_reset got core_rst %b busy %b want 0 0", coreRst, busy);
    else passes++;
  endtask

  task automatic test_two_words();
    byteQ_t b;
    b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(8'h70);
`endif
    writeCycles.delete();
    expQ.push_back('{addr: 32'h0, data: 32'h00500513});
    expQ.push_back('{addr: 32'h4, data: 32'h00A00593});
    pulseStart(2);
    applyStimulus(b, 1'b0);
    waitIdle(40);
    checks++;
    if (done !== 1'b1 || coreRst !== 1'b1 || err !== 1'b0)
      $display("[TB] FAIL two_words_status got done %b core_rst %b err %b want 1 1 0", done, coreRst, err);
    else passes++;
    checks++;
    if (expQ.size() != 0) $display("[TB] FAIL two_words_pending got %0d want 0", expQ.size());
    else passes++;
    checks++;
    if (writeCycles.size() != 2) $display("[TB] FAIL two_words_count got %0d want 2", writeCycles.size());
    else if (writeCycles[1] - writeCycles[0] != 5)
      $display("[TB] FAIL write_spacing got %0d want 5", writeCycles[1] - writeCycles[0]);
    else passes++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    byteQ_t b;
    b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00, 8'h71};
    expQ.push_back('{addr: 32'h0, data: 32'h00500513});
    expQ.push_back('{addr: 32'h4, data: 32'h00A00593});
    pulseStart(2);
    applyStimulus(b, 1'b0);
    waitIdle(40);
    checks++;
    if (err !== 1'b1 || coreRst !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL checksum_bad got err %b core_rst %b done %b want 1 0 0", err, coreRst, done);
    else passes++;
  endtask
`endif

  task automatic test_backpressure();
    byteQ_t b;
    b = '{8'h13, 8'h05, 8'h50, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(8'h46);
`endif
    writeCycles.delete();
    expQ.push_back('{addr: 32'h0, data: 32'h00500513});
    pulseStart(1);
    applyStimulus(b, 1'b1);
    waitIdle(40);
    checks++;
    if (done !== 1'b1 || expQ.size() != 0 || writeCycles.size() != 1)
      $display("[TB] FAIL backpressure got done %b pending %0d writes %0d want 1 0 1", done, expQ.size(), writeCycles.size());
    else passes++;
  endtask

  task automatic test_len_zero();
    writeCycles.delete();
    @(posedge clk);
    #1;
    start    = 1'b1;
    lenWords = '0;
    @(posedge clk);
    #1;
    start    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL len_zero_check got busy %b want 1", busy);
    else passes++;
    begin
      byteQ_t b;
      b = '{8'h00};
      applyStimulus(b, 1'b0);
    end
    waitIdle(10);
`endif
`ifndef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL len_zero_done got done %b busy %b want 1 0", done, busy);
    else passes++;
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || writeCycles.size() != 0)
      $display("[TB] FAIL len_zero_writes got done %b writes %0d want 1 0", done, writeCycles.size());
    else passes++;
  endtask

  task automatic test_async_reset();
    byteQ_t b;
    b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05};
    expQ.push_back('{addr: 32'h0, data: 32'h00500513});
    pulseStart(2);
    applyStimulus(b, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.im_we, bus.im_addr, bus.im_wdata, coreRst, busy, done, err} !== '0)
      $display("[TB] FAIL async_reset_outputs got %b%b %h %h %b%b%b%b want all zero",
               bus.s_ready, bus.im_we, bus.im_addr, bus.im_wdata, coreRst, busy, done, err);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    writeCycles.delete();
    repeat (6) @(negedge clk);
    checks++;
    if (writeCycles.size() != 0 || busy !== 1'b0 || expQ.size() != 0)
      $display("[TB] FAIL after_reset got writes %0d busy %b pending %0d want 0 0 0", writeCycles.size(), busy, expQ.size());
    else passes++;
    b = '{8'h78, 8'h56, 8'h34, 8'h12};
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(8'h08);
`endif
    expQ.push_back('{addr: 32'h0, data: 32'h12345678});
    pulseStart(1);
    applyStimulus(b, 1'b0);
    waitIdle(40);
    checks++;
    if (done !== 1'b1 || coreRst !== 1'b1 || expQ.size() != 0)
      $display("[TB] FAIL fresh_load got done %b core_rst %b pending %0d want 1 1 0", done, coreRst, expQ.size());
    else passes++;
  endtask

  task automatic test_start_during_load();
    byteQ_t b;
    writeCycles.delete();
    expQ.push_back('{addr: 32'h0, data: 32'h00500513});
    expQ.push_back('{addr: 32'h4, data: 32'h00A00593});
    pulseStart(2);
    b = '{8'h13, 8'h05};
    applyStimulus(b, 1'b0);
    start    = 1'b1;
    lenWords = 11'd5;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lenWords = '0;
    b = '{8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(8'h70);
`endif
    applyStimulus(b, 1'b0);
    waitIdle(40);
    checks++;
    if (done !== 1'b1 || expQ.size() != 0 || writeCycles.size() != 2)
      $display("[TB] FAIL start_in_load got done %b pending %0d writes %0d want 1 0 2", done, expQ.size(), writeCycles.size());
    else passes++;
  endtask

  task automatic test_clamp();
    byteQ_t b;
    logic [7:0] v;
    writeCycles.delete();
    for (int k = 0; k < (1 << ADDR_W); k++) begin
      logic [31:0] w;
      for (int j = 0; j < 4; j++) begin
        v = 8'((4 * k + j) & 255);
        b.push_back(v);
        w[8*j +: 8] = v;
      end
      expQ.push_back('{addr: 32'(4 * k), data: w});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(8'h00);
`endif
    pulseStart(11'h7FF);
    applyStimulus(b, 1'b0);
    waitIdle(50);
    checks++;
    if (done !== 1'b1 || expQ.size() != 0 || writeCycles.size() != (1 << ADDR_W))
      $display("[TB] FAIL clamp got done %b pending %0d writes %0d want 1 0 %0d",
               done, expQ.size(), writeCycles.size(), 1 << ADDR_W);
    else passes++;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    test_reset();
    test_two_words();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    test_backpressure();
    test_len_zero();
    test_async_reset();
    test_start_during_load();
    test_clamp();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
